// File: rtl/fifo_drain_pkg.sv
// Shared constants, state encoding and byte helpers for the FIFO byte drain.
package fifo_drain_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 16;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_SEND = ST_SEND
  } drain_state_e;

  // Picks byte 'idx' of a word; idx 0 is bits 7:0 when lsb_first, else bits 31:24.
  function automatic logic [BYTE_W-1:0] sel_byte(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        idx,
    input logic              lsb_first
  );
    logic [1:0] pos_s;
    if (lsb_first) begin
      pos_s = idx;
    end else begin
      pos_s = 2'd3 - idx;
    end
    return word[{pos_s, 3'b000} +: BYTE_W];
  endfunction

  // Even parity bit of a byte (XOR reduction).
  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/fifo_byte_drain.sv
// Pops 32-bit words from a first-word-fall-through FIFO and streams them out
// as bytes on a valid/ready interface, with a wrapping count of popped words.
// Optional feature macro: FIFO_DRAIN_PARITY_EN adds a registered byte_parity output.
module fifo_byte_drain
  import fifo_drain_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter bit LSB_FIRST      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] out_fifo,
  input  logic              empty,
  output logic              read_fifo_en,
  input  logic              drain_en,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  words_drained
`ifdef FIFO_DRAIN_PARITY_EN
  ,
  output logic              byte_parity
`endif
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  drain_state_e      state_r, state_nxt_s;
  logic [WORD_W-1:0] word_r, word_nxt_s;
  logic [1:0]        idx_r, idx_nxt_s;
  logic [BYTE_W-1:0] byte_r, byte_nxt_s;
  logic              valid_r;
  logic              busy_r;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              last_hs_s;
  logic              pop_s;

  // Pop decision and next-state / next-byte selection.
  always_comb begin
    state_nxt_s = state_r;
    word_nxt_s  = word_r;
    idx_nxt_s   = idx_r;
    byte_nxt_s  = byte_r;
    cnt_nxt_s   = cnt_r;
    last_hs_s   = (state_r == S_SEND) && byte_ready && (idx_r == LAST_IDX);
    pop_s       = !reset && drain_en && !empty && ((state_r == S_IDLE) || last_hs_s);
    if (pop_s) begin
      // Pop and latch on the same edge; also covers back-to-back words.
      state_nxt_s = S_SEND;
      word_nxt_s  = out_fifo;
      idx_nxt_s   = 2'd0;
      byte_nxt_s  = sel_byte(out_fifo, 2'd0, LSB_FIRST);
      cnt_nxt_s   = cnt_r + 16'd1;
    end else begin
      case (state_r)
        S_SEND: begin
          if (byte_ready) begin
            if (idx_r == LAST_IDX) begin
              state_nxt_s = S_IDLE;
              idx_nxt_s   = 2'd0;
              byte_nxt_s  = 8'h00;
            end else begin
              idx_nxt_s  = idx_r + 2'd1;
              byte_nxt_s = sel_byte(word_r, idx_r + 2'd1, LSB_FIRST);
            end
          end else begin
            // Stall: hold byte and index.
            idx_nxt_s  = idx_r;
            byte_nxt_s = byte_r;
          end
        end
        S_IDLE: begin
          state_nxt_s = S_IDLE;
        end
        default: begin
          state_nxt_s = S_IDLE;
          idx_nxt_s   = 2'd0;
          byte_nxt_s  = 8'h00;
        end
      endcase
    end
  end

  // State, word, index, output and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      word_r  <= 32'h0000_0000;
      idx_r   <= 2'd0;
      byte_r  <= 8'h00;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      cnt_r   <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      word_r  <= word_nxt_s;
      idx_r   <= idx_nxt_s;
      byte_r  <= byte_nxt_s;
      valid_r <= (state_nxt_s == S_SEND);
      busy_r  <= (state_nxt_s == S_SEND);
      cnt_r   <= cnt_nxt_s;
    end
  end

`ifdef FIFO_DRAIN_PARITY_EN
  logic parity_r;

  // Parity register tracks the byte register one-for-one.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= even_parity(byte_nxt_s);
    end
  end

  assign byte_parity = parity_r;
`endif

  assign read_fifo_en  = pop_s;
  assign byte_data     = byte_r;
  assign byte_valid    = valid_r;
  assign busy          = busy_r;
  assign words_drained = cnt_r;

endmodule

// File: tb/tb_fifo_byte_drain.sv
// Directed bench for fifo_byte_drain: FIFO model plus byte scoreboard, and a
// second single-byte instance for the counter wrap.
module tb_fifo_byte_drain;

  logic        clk = 1'b0;
  logic        reset, drain_en, byte_ready, empty;
  logic [31:0] out_fifo;
  logic        read_fifo_en, byte_valid, busy;
  logic [7:0]  byte_data;
  logic [15:0] words_drained;

  logic        reset2, drain2;
  logic        rd2, valid2, busy2;
  logic [7:0]  data2;
  logic [15:0] words2;

`ifdef FIFO_DRAIN_PARITY_EN
  logic        byte_parity, parity2;
`endif

  int total = 0;
  int bad   = 0;
  int pops2 = 0;

  logic [31:0] fifo_q[$];
  logic [7:0]  sb_q[$];
  logic        s_valid, s_ready, s_rd, s_rd2;
  logic [7:0]  s_data;
  logic        s_par;

  always #5 clk = ~clk;

  fifo_byte_drain #(.BYTES_PER_WORD(4), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .out_fifo(out_fifo), .empty(empty),
    .read_fifo_en(read_fifo_en), .drain_en(drain_en), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy),
    .words_drained(words_drained)
`ifdef FIFO_DRAIN_PARITY_EN
    , .byte_parity(byte_parity)
`endif
  );

  fifo_byte_drain #(.BYTES_PER_WORD(1), .LSB_FIRST(1'b1)) dut2 (
    .clk(clk), .reset(reset2), .out_fifo(32'h1234_5607), .empty(1'b0),
    .read_fifo_en(rd2), .drain_en(drain2), .byte_data(data2),
    .byte_valid(valid2), .byte_ready(1'b1), .busy(busy2),
    .words_drained(words2)
`ifdef FIFO_DRAIN_PARITY_EN
    , .byte_parity(parity2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_fifo();
    empty    = (fifo_q.size() == 0);
    out_fifo = empty ? 32'h0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    for (int i = 0; i < 4; i++) sb_q.push_back(w[8*i +: 8]);
    upd_fifo();
  endtask

  // One clock: sample at negedge, apply FIFO pop just after posedge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    s_valid = byte_valid;
    s_ready = byte_ready;
    s_data  = byte_data;
    s_rd    = read_fifo_en;
    s_rd2   = rd2;
`ifdef FIFO_DRAIN_PARITY_EN
    s_par   = byte_parity;
`else
    s_par   = 1'b0;
`endif
    if (s_valid && s_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_byte", 32'(s_data), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("byte", 32'(s_data), 32'(e));
`ifdef FIFO_DRAIN_PARITY_EN
        check("parity", 32'(s_par), 32'(^e));
`endif
      end
    end
    @(posedge clk);
    #1;
    if (s_rd) begin
      if (fifo_q.size() == 0) check("pop_when_empty", 32'd1, 32'd0);
      else void'(fifo_q.pop_front());
    end
    if (s_rd2) pops2++;
    upd_fifo();
  endtask

  initial begin
    reset = 1'b1; drain_en = 1'b0; byte_ready = 1'b0;
    reset2 = 1'b1; drain2 = 1'b1;
    upd_fifo();
    tick(); tick();

    // Reset state, and no pop while reset even with data present
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(byte_data), 32'd0);
    check("rst_words", 32'(words_drained), 32'd0);
    push_word(32'h4433_2211);
    drain_en = 1'b1; byte_ready = 1'b1;
    #1;
    check("rst_no_pop", 32'(read_fifo_en), 32'd0);
    check("rst2_no_pop", 32'(rd2), 32'd0);

    // Test 1: single word, bytes on consecutive cycles
    reset = 1'b0;
    #1;
    check("t1_pop", 32'(read_fifo_en), 32'd1);
    tick();
    check("t1_valid", 32'(byte_valid), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_first", 32'(byte_data), 32'h11);
    check("t1_words", 32'(words_drained), 32'd1);
    check("t1_no_pop", 32'(read_fifo_en), 32'd0);
    tick(); tick(); tick();
    check("t1_last", 32'(byte_data), 32'h44);
    tick();
    check("t1_idle_valid", 32'(byte_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // Test 2: two words back-to-back, second pop on 0xA0 handshake
    push_word(32'hA0B0_C0D0);
    push_word(32'h0102_0304);
    #1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t2_no_bubble", 32'(byte_valid), 32'd1);
      tick();
      check("t2_pop_timing", 32'(s_rd), 32'(i == 3));
    end
    check("t2_idle", 32'(busy), 32'd0);
    check("t2_words", 32'(words_drained), 32'd3);
    check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // Test 3: stall on byte 2
    push_word(32'hDEAD_BEEF);
    #1;
    tick(); tick(); tick();
    check("t3_pre", 32'(byte_data), 32'hAD);
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_stall_valid", 32'(byte_valid), 32'd1);
      check("t3_stall_data", 32'(byte_data), 32'hAD);
    end
    byte_ready = 1'b1;
    tick();
    check("t3_resume", 32'(byte_data), 32'hDE);
    tick();
    check("t3_idle", 32'(byte_valid), 32'd0);
    check("t3_words", 32'(words_drained), 32'd4);

    // Test 4: drain_en dropped after first byte
    push_word(32'h0A0B_0C0D);
    push_word(32'h5566_7788);
    #1;
    tick(); tick();
    drain_en = 1'b0;
    tick(); tick(); tick();
    check("t4_no_second_pop", 32'(s_rd), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_not_empty", 32'(empty), 32'd0);
    check("t4_fifo_left", 32'(fifo_q.size()), 32'd1);
    tick(); tick();
    check("t4_still_idle", 32'(byte_valid), 32'd0);
    check("t4_words", 32'(words_drained), 32'd5);
    drain_en = 1'b1;
    #1;
    check("t4_resume_pop", 32'(read_fifo_en), 32'd1);
    tick(); tick(); tick(); tick(); tick();
    check("t4_words2", 32'(words_drained), 32'd6);
    check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // Test 5: reset on byte 1 discards the partial word
    push_word(32'h8765_4321);
    push_word(32'h0F0E_0D0C);
    #1;
    tick(); tick();
    check("t5_byte1", 32'(byte_data), 32'h43);
    reset = 1'b1; byte_ready = 1'b0;
    #1;
    check("t5_rst_no_pop", 32'(read_fifo_en), 32'd0);
    tick();
    check("t5_valid", 32'(byte_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_words", 32'(words_drained), 32'd0);
    check("t5_data", 32'(byte_data), 32'd0);
    check("t5_rst_no_pop2", 32'(read_fifo_en), 32'd0);
    for (int i = 0; i < 3; i++) void'(sb_q.pop_front());
    reset = 1'b0; byte_ready = 1'b1;
    #1;
    check("t5_fresh_pop", 32'(read_fifo_en), 32'd1);
    tick();
    check("t5_fresh_byte", 32'(byte_data), 32'h0C);
    check("t5_fresh_words", 32'(words_drained), 32'd1);
    tick(); tick(); tick(); tick();
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_fifo_empty", 32'(empty), 32'd1);
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // Test 6: single-byte words, counter wrap
    reset2 = 1'b0;
    pops2 = 0;
    for (int i = 0; i < 65536; i++) begin
      tick();
      if (i == 0) begin
        check("t6_byte", 32'(data2), 32'h07);
        check("t6_valid", 32'(valid2), 32'd1);
`ifdef FIFO_DRAIN_PARITY_EN
        check("t6_parity", 32'(parity2), 32'd1);
`endif
      end
      if (i == 65534) check("t6_ffff", 32'(words2), 32'h0000_FFFF);
    end
    drain2 = 1'b0;
    check("t6_pops", 32'(pops2), 32'd65536);
    check("t6_wrap", 32'(words2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
